// File: rtl/rtc_calendar_scan_if.sv
// ----------------------------------------------------------------------------
// rtc_calendar_scan_if
// Bundles the user-facing signals of the RTC/calendar block: the operator
// controls (display mode, set enable, up/down keys, alarm enable) and the
// outputs (7-segment pattern, one-hot digit enable, 1 s tick and alarm).
//   master : the board / stimulus side, drives the controls, reads outputs
//   slave  : the rtc_calendar_scan core
// ----------------------------------------------------------------------------
interface rtc_calendar_scan_if;
  logic [1:0] mode;      // 00 time, 01 date, 10 alarm, 11 time
  logic       set_en;    // adjust fields of the displayed mode
  logic       up;        // key level, minor field step on rising edge
  logic       down;      // key level, major field step on rising edge
  logic       alarm_en;  // alarm may fire
  logic [6:0] Out;       // segments {g,f,e,d,c,b,a}
  logic [5:0] control;   // one-hot digit enable, bit0 = leftmost digit
  logic       tick_1s;   // one-cycle pulse per second
  logic       alarm;     // alarm active

  modport master (
    output mode, set_en, up, down, alarm_en,
    input  Out, control, tick_1s, alarm
  );

  modport slave (
    input  mode, set_en, up, down, alarm_en,
    output Out, control, tick_1s, alarm
  );
endinterface

// File: rtl/rtc_calendar_scan.sv
// ----------------------------------------------------------------------------
// rtc_calendar_scan
// Real-time clock/calendar with hh:mm alarm and a 6-digit multiplexed
// 7-segment driver. Time (hh:mm:ss) and date (dd/mm/yy, 2000..2099) are held
// in BCD with true month lengths and leap years.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset (dominates everything)
//   bus    : rtc_calendar_scan_if.slave
//            in  mode[1:0], set_en, up, down, alarm_en
//            out Out[6:0], control[5:0], tick_1s, alarm
// ----------------------------------------------------------------------------
module rtc_calendar_scan #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int SCAN_DIV   = 100_000,
  parameter bit SEG_ACT_LO = 1'b1,
  parameter int ALARM_LEN  = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  rtc_calendar_scan_if.slave   bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [7:0]    ALEN      = 8'(ALARM_LEN);
  localparam logic [6:0]    SEG_BLANK = SEG_ACT_LO ? 7'h7F : 7'h00;

  // ---------------------------------------------------------------- helpers
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_wrap(input logic [7:0] v,
                                          input logic [7:0] last,
                                          input logic [7:0] first);
    bcd_wrap = (v == last) ? first : bcd_inc(v);
  endfunction

  // yy%4==0 in BCD: even tens need ones 0/4/8, odd tens need ones 2/6.
  function automatic logic [7:0] month_len(input logic [7:0] mo,
                                           input logic [7:0] yy);
    logic leap;
    leap = yy[4] ? (yy[3:0] == 4'd2 || yy[3:0] == 4'd6)
                 : (yy[3:0] == 4'd0 || yy[3:0] == 4'd4 || yy[3:0] == 4'd8);
    case (mo)
      8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
      8'h02:                      month_len = leap ? 8'h29 : 8'h28;
      default:                    month_len = 8'h31;
    endcase
  endfunction

  // Active-low pattern, 0 = lit.
  function automatic logic [6:0] seg_enc(input logic [3:0] dgt);
    case (dgt)
      4'd0: seg_enc = 7'b1000000;
      4'd1: seg_enc = 7'b1111001;
      4'd2: seg_enc = 7'b0100100;
      4'd3: seg_enc = 7'b0110000;
      4'd4: seg_enc = 7'b0011001;
      4'd5: seg_enc = 7'b0010010;
      4'd6: seg_enc = 7'b0000010;
      4'd7: seg_enc = 7'b1111000;
      4'd8: seg_enc = 7'b0000000;
      4'd9: seg_enc = 7'b0010000;
      default: seg_enc = 7'b1111111;
    endcase
  endfunction

  // ---------------------------------------------------------------- state
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    digit_idx_q, digit_idx_d;
  logic [5:0]    control_q, control_d;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [7:0]    day_q, day_d, month_q, month_d, year_q, year_d;
  logic [7:0]    al_min_q, al_min_d, al_hour_q, al_hour_d;
  logic [7:0]    alarm_cnt_q, alarm_cnt_d;
  logic [1:0]    key_s1_q, key_s1_d, key_s2_q, key_s2_d;  // {down, up}

  logic          tick_now;
  logic [1:0]    key_rise;
  logic          time_mode, date_mode;
  logic [7:0]    mo_set, max_set, day_set;
  logic [23:0]   disp_digits;
  logic [3:0]    nib;

  assign tick_now  = (tick_cnt_q == TICK_LAST);
  assign key_rise  = key_s1_q & ~key_s2_q;
  assign time_mode = (bus.mode == 2'b00) || (bus.mode == 2'b11);
  assign date_mode = (bus.mode == 2'b01);

  always_comb begin
    tick_cnt_d  = tick_now ? '0 : tick_cnt_q + 1'b1;
    scan_cnt_d  = scan_cnt_q;
    digit_idx_d = digit_idx_q;
    control_d   = control_q;
    seg_d       = seg_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    al_min_d    = al_min_q;
    al_hour_d   = al_hour_q;
    alarm_cnt_d = alarm_cnt_q;
    key_s1_d    = {bus.down, bus.up};
    key_s2_d    = key_s1_q;
    mo_set      = month_q;
    max_set     = month_len(month_q, year_q);
    day_set     = day_q;
    disp_digits = {hour_q, min_q, sec_q};
    nib         = 4'd0;

    // Carry chain; time is held while it is being adjusted.
    if (tick_now && !(bus.set_en && time_mode)) begin
      if (sec_q != 8'h59) begin
        sec_d = bcd_inc(sec_q);
      end else begin
        sec_d = 8'h00;
        if (min_q != 8'h59) begin
          min_d = bcd_inc(min_q);
        end else begin
          min_d = 8'h00;
          if (hour_q != 8'h23) begin
            hour_d = bcd_inc(hour_q);
          end else begin
            hour_d = 8'h00;
            if (day_q != month_len(month_q, year_q)) begin
              day_d = bcd_inc(day_q);
            end else begin
              day_d = 8'h01;
              if (month_q != 8'h12) begin
                month_d = bcd_inc(month_q);
              end else begin
                month_d = 8'h01;
                year_d  = bcd_wrap(year_q, 8'h99, 8'h00);
              end
            end
          end
        end
      end
    end

    // Key steps are computed from the registered values and override only
    // the fields they touch; a coincident tick still moves the others.
    if (bus.set_en) begin
      if (time_mode) begin
        if (key_rise[0]) begin
          min_d = bcd_wrap(min_q, 8'h59, 8'h00);
          sec_d = 8'h00;
        end
        if (key_rise[1]) hour_d = bcd_wrap(hour_q, 8'h23, 8'h00);
      end else if (date_mode) begin
        // Month first, then clamp day, then step day within the new month.
        mo_set  = key_rise[0] ? bcd_wrap(month_q, 8'h12, 8'h01) : month_q;
        max_set = month_len(mo_set, year_q);
        day_set = (day_q > max_set) ? max_set : day_q;
        if (key_rise[1]) day_set = bcd_wrap(day_set, max_set, 8'h01);
        if (key_rise[0]) month_d = mo_set;
        if (key_rise[0] || key_rise[1]) day_d = day_set;
      end else begin
        if (key_rise[0]) al_min_d  = bcd_wrap(al_min_q, 8'h59, 8'h00);
        if (key_rise[1]) al_hour_d = bcd_wrap(al_hour_q, 8'h23, 8'h00);
      end
    end

    // Alarm compares the time as it will be after this edge.
    if (!bus.alarm_en) begin
      alarm_cnt_d = 8'd0;
    end else if (tick_now) begin
      if (hour_d == al_hour_q && min_d == al_min_q && sec_d == 8'h00)
        alarm_cnt_d = ALEN;
      else if (alarm_cnt_q != 8'd0)
        alarm_cnt_d = alarm_cnt_q - 8'd1;
    end

    // Digit scan: next digit's pattern and enable are loaded together.
    case (bus.mode)
      2'b01:   disp_digits = {day_q, month_q, year_q};
      2'b10:   disp_digits = {al_hour_q, al_min_q, 8'h00};
      default: disp_digits = {hour_q, min_q, sec_q};
    endcase
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d  = '0;
      digit_idx_d = (digit_idx_q == 3'd5) ? 3'd0 : digit_idx_q + 3'd1;
      control_d   = 6'b000001 << digit_idx_d;
      case (digit_idx_d)
        3'd0:    nib = disp_digits[23:20];
        3'd1:    nib = disp_digits[19:16];
        3'd2:    nib = disp_digits[15:12];
        3'd3:    nib = disp_digits[11:8];
        3'd4:    nib = disp_digits[7:4];
        default: nib = disp_digits[3:0];
      endcase
      seg_d = SEG_ACT_LO ? seg_enc(nib) : ~seg_enc(nib);
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      scan_cnt_q  <= '0;
      digit_idx_q <= 3'd0;
      control_q   <= 6'b000001;
      seg_q       <= SEG_BLANK;
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      hour_q      <= 8'h00;
      day_q       <= 8'h01;
      month_q     <= 8'h01;
      year_q      <= 8'h00;
      al_min_q    <= 8'h00;
      al_hour_q   <= 8'h00;
      alarm_cnt_q <= 8'd0;
      // Seed with the live levels so a key held through reset is no edge.
      key_s1_q    <= {bus.down, bus.up};
      key_s2_q    <= {bus.down, bus.up};
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      control_q   <= control_d;
      seg_q       <= seg_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      al_min_q    <= al_min_d;
      al_hour_q   <= al_hour_d;
      alarm_cnt_q <= alarm_cnt_d;
      key_s1_q    <= key_s1_d;
      key_s2_q    <= key_s2_d;
    end
  end

  assign bus.Out     = seg_q;
  assign bus.control = control_q;
  assign bus.tick_1s = tick_now;
  assign bus.alarm   = (alarm_cnt_q != 8'd0);

endmodule
